// File: rtl/dfe_regs_pkg.sv
// Shared constants for the dfe_top APB register bank: register map, CTRL fields,
// coefficient reset sets and the block ID.
package dfe_regs_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_N1     = 8'h04;
    localparam logic [7:0] OFF_N2     = 8'h18;
    localparam logic [7:0] OFF_COMMIT = 8'h2C;
    localparam logic [7:0] OFF_STATUS = 8'h30;
    localparam logic [7:0] OFF_ID     = 8'h34;

    localparam int unsigned NUM_SLOTS = 5;

    localparam int unsigned CTRL_FD_EN      = 0;
    localparam int unsigned CTRL_FD_BYP     = 1;
    localparam int unsigned CTRL_N1_EN      = 2;
    localparam int unsigned CTRL_N1_BYP     = 3;
    localparam int unsigned CTRL_N2_EN      = 4;
    localparam int unsigned CTRL_N2_BYP     = 5;
    localparam int unsigned CTRL_CIC_EN     = 6;
    localparam int unsigned CTRL_CIC_BYP    = 7;
    localparam int unsigned CTRL_CLKDIV_EN  = 8;
    localparam int unsigned CTRL_DEC_LSB    = 9;
    localparam int unsigned CTRL_WIDTH      = 12;

    localparam logic [CTRL_WIDTH-1:0] CTRL_RST = 12'h0AA;
    localparam logic [2:0]            MAX_DEC_K = 3'd4;

    // Slot 0 (b0) in the low 16 bits, a2 in the top 16 bits.
    localparam logic [79:0] N1_RST = {16'h3C38, 16'h6473, 16'h4000, 16'h678E, 16'h4000};
    localparam logic [79:0] N2_RST = {16'h3C38, 16'hC1EC, 16'h4000, 16'hC000, 16'h4000};

    localparam logic [31:0] ID_VALUE = 32'hDFE0_0001;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_N1,
        REG_N2,
        REG_COMMIT,
        REG_STATUS,
        REG_ID,
        REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/dfe_coeff_bank.sv
// Double-buffered notch coefficient set: shadow registers written over APB,
// copied to the active set in one edge on commit.
module dfe_coeff_bank
    import dfe_regs_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter logic [79:0]  RST_COEFF  = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_en_i,
    input  logic [2:0]                    slot_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          commit_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          pending_o,
    output logic [NUM_SLOTS*DATA_WIDTH-1:0] active_o
);

    logic [DATA_WIDTH-1:0] shadow_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] active_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] active_d [NUM_SLOTS];
    logic                  pending_q;
    logic                  pending_d;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (wr_en_i) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if (slot_i == 3'(k)) shadow_d[k] = wr_data_i;
            end
            pending_d = 1'b1;
        end
        if (commit_i) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                shadow_q[k] <= DATA_WIDTH'(RST_COEFF[16*k +: 16]);
                active_q[k] <= DATA_WIDTH'(RST_COEFF[16*k +: 16]);
            end
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        active_o  = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (slot_i == 3'(k)) rd_data_o = shadow_q[k];
            active_o[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/dfe_apb_regs.sv
// APB3 register bank for dfe_top: CTRL (applies immediately), two double-buffered
// notch coefficient banks, commit/status/ID, with a configurable wait-state count.
module dfe_apb_regs
    import dfe_regs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [31:0]             PWDATA,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [4:0]              ctrl_en,
    output logic [3:0]              ctrl_bypass,
    output logic [2:0]              cic_dec_factor,
    output logic [5*DATA_WIDTH-1:0] coeff_notch_1,
    output logic [5*DATA_WIDTH-1:0] coeff_notch_2
);

    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  access;
    logic [31:0]           off;
    reg_sel_e              sel;
    logic [2:0]            slot;
    logic                  err;
    logic                  wr_ok;
    logic [31:0]           rdata;
    logic [DATA_WIDTH-1:0] n1_rd, n2_rd;
    logic                  n1_pend, n2_pend;
    logic                  unused_bits;

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign access = PSEL & PENABLE;
    assign off    = 32'({PADDR[ADDR_WIDTH-1:2], 2'b00});

    always_comb begin
        cnt_d = cnt_q;
        if (!access)                         cnt_d = '0;
        else if (cnt_q != 2'(WAIT_STATES))   cnt_d = cnt_q + 2'd1;
    end

    // Gated with RST so an access phase held across reset never reports completion.
    assign PREADY = access & (cnt_q == 2'(WAIT_STATES)) & RST;

    always_comb begin
        sel  = REG_NONE;
        slot = '0;
        if (off == 32'(OFF_CTRL))   sel = REG_CTRL;
        if (off == 32'(OFF_COMMIT)) sel = REG_COMMIT;
        if (off == 32'(OFF_STATUS)) sel = REG_STATUS;
        if (off == 32'(OFF_ID))     sel = REG_ID;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (off == 32'(OFF_N1) + 32'(4*k)) begin
                sel  = REG_N1;
                slot = 3'(k);
            end
            if (off == 32'(OFF_N2) + 32'(4*k)) begin
                sel  = REG_N2;
                slot = 3'(k);
            end
        end
    end

    always_comb begin
        err   = 1'b0;
        rdata = '0;
        case (sel)
            REG_CTRL: begin
                rdata = 32'(ctrl_q);
                err   = PWRITE && (PWDATA[CTRL_DEC_LSB +: 3] > MAX_DEC_K);
            end
            REG_N1:     rdata = 32'(n1_rd);
            REG_N2:     rdata = 32'(n2_rd);
            REG_COMMIT: rdata = '0;
            REG_STATUS: begin
                rdata = {30'd0, n2_pend, n1_pend};
                err   = PWRITE;
            end
            REG_ID: begin
                rdata = ID_VALUE;
                err   = PWRITE;
            end
            default:    err = 1'b1;
        endcase
    end

    assign wr_ok   = PREADY & PWRITE & ~err;
    assign PRDATA  = PREADY ? rdata : '0;
    assign PSLVERR = PREADY & err;

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ok && sel == REG_CTRL) ctrl_d = PWDATA[CTRL_WIDTH-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctrl_q <= CTRL_RST;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ctrl_en        = {ctrl_q[CTRL_CLKDIV_EN], ctrl_q[CTRL_CIC_EN], ctrl_q[CTRL_N2_EN],
                             ctrl_q[CTRL_N1_EN], ctrl_q[CTRL_FD_EN]};
    assign ctrl_bypass    = {ctrl_q[CTRL_CIC_BYP], ctrl_q[CTRL_N2_BYP], ctrl_q[CTRL_N1_BYP],
                             ctrl_q[CTRL_FD_BYP]};
    assign cic_dec_factor = ctrl_q[CTRL_DEC_LSB +: 3];

    dfe_coeff_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_COEFF  (N1_RST)
    ) u_bank_n1 (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .wr_en_i   (wr_ok && sel == REG_N1),
        .slot_i    (slot),
        .wr_data_i (PWDATA[DATA_WIDTH-1:0]),
        .commit_i  (wr_ok && sel == REG_COMMIT && PWDATA[0]),
        .rd_data_o (n1_rd),
        .pending_o (n1_pend),
        .active_o  (coeff_notch_1)
    );

    dfe_coeff_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_COEFF  (N2_RST)
    ) u_bank_n2 (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .wr_en_i   (wr_ok && sel == REG_N2),
        .slot_i    (slot),
        .wr_data_i (PWDATA[DATA_WIDTH-1:0]),
        .commit_i  (wr_ok && sel == REG_COMMIT && PWDATA[1]),
        .rd_data_o (n2_rd),
        .pending_o (n2_pend),
        .active_o  (coeff_notch_2)
    );

endmodule

// File: tb/tb_dfe_apb_regs.sv
// Directed bench for dfe_apb_regs: zero-wait instance for the register map and
// a three-wait-state instance for APB timing.
module tb_dfe_apb_regs;

    localparam logic [79:0] EXP_N1_RST = {16'h3C38, 16'h6473, 16'h4000, 16'h678E, 16'h4000};
    localparam logic [79:0] EXP_N2_RST = {16'h3C38, 16'hC1EC, 16'h4000, 16'hC000, 16'h4000};

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        PSEL = 1'b0, PSEL3 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;

    logic [31:0] PRDATA, PRDATA3;
    logic        PREADY, PREADY3, PSLVERR, PSLVERR3;
    logic [4:0]  ctrl_en, ctrl_en3;
    logic [3:0]  ctrl_bypass, ctrl_bypass3;
    logic [2:0]  cic_dec_factor, cic_dec_factor3;
    logic [79:0] coeff_notch_1, coeff_notch_2, coeff3_1, coeff3_2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    dfe_apb_regs #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut (
        .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .ctrl_en(ctrl_en), .ctrl_bypass(ctrl_bypass),
        .cic_dec_factor(cic_dec_factor), .coeff_notch_1(coeff_notch_1),
        .coeff_notch_2(coeff_notch_2)
    );

    dfe_apb_regs #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
        .CLK(CLK), .RST(RST), .PSEL(PSEL3), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA3), .PREADY(PREADY3),
        .PSLVERR(PSLVERR3), .ctrl_en(ctrl_en3), .ctrl_bypass(ctrl_bypass3),
        .cic_dec_factor(cic_dec_factor3), .coeff_notch_1(coeff3_1),
        .coeff_notch_2(coeff3_2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic xfer(input bit d3, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] er, input bit ee, input string tag);
        exp_t e;
        int   n;
        e.rdata = er; e.err = ee; e.chk_rd = !wr; e.tag = tag;
        sb.push_back(e);
        @(posedge CLK); #1;
        if (d3) PSEL3 = 1'b1; else PSEL = 1'b1;
        PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        @(negedge CLK);
        n = 0;
        while (((d3 ? PREADY3 : PREADY) !== 1'b1) && n < 16) begin
            @(negedge CLK);
            n++;
        end
        e = sb.pop_front();
        chk({e.tag, ":pready"}, 128'(d3 ? PREADY3 : PREADY), 128'(1'b1));
        if (e.chk_rd) chk({e.tag, ":prdata"}, 128'(d3 ? PRDATA3 : PRDATA), 128'(e.rdata));
        chk({e.tag, ":pslverr"}, 128'(d3 ? PSLVERR3 : PSLVERR), 128'(e.err));
        @(posedge CLK); #1;
        PSEL = 1'b0; PSEL3 = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #23;
        chk("rst_pready", 128'(PREADY), 128'(1'b0));
        chk("rst_pslverr", 128'(PSLVERR), 128'(1'b0));
        chk("rst_prdata", 128'(PRDATA), 128'(32'h0));
        chk("rst_ctrl_en", 128'(ctrl_en), 128'(5'h00));
        chk("rst_bypass", 128'(ctrl_bypass), 128'(4'hF));
        chk("rst_dec", 128'(cic_dec_factor), 128'(3'd0));
        chk("rst_n1_active", 128'(coeff_notch_1), 128'(EXP_N1_RST));
        chk("rst_n2_active", 128'(coeff_notch_2), 128'(EXP_N2_RST));
        @(posedge CLK); #1 RST = 1'b1;
        idle(1);

        xfer(0, 0, 8'h00, '0, 32'h0AA, 0, "rd_ctrl");
        xfer(0, 0, 8'h04, '0, 32'h4000, 0, "rd_n1_b0");
        xfer(0, 0, 8'h08, '0, 32'h678E, 0, "rd_n1_b1");
        xfer(0, 0, 8'h0C, '0, 32'h4000, 0, "rd_n1_b2");
        xfer(0, 0, 8'h10, '0, 32'h6473, 0, "rd_n1_a1");
        xfer(0, 0, 8'h14, '0, 32'h3C38, 0, "rd_n1_a2");
        xfer(0, 0, 8'h18, '0, 32'h4000, 0, "rd_n2_b0");
        xfer(0, 0, 8'h1C, '0, 32'hC000, 0, "rd_n2_b1");
        xfer(0, 0, 8'h20, '0, 32'h4000, 0, "rd_n2_b2");
        xfer(0, 0, 8'h24, '0, 32'hC1EC, 0, "rd_n2_a1");
        xfer(0, 0, 8'h28, '0, 32'h3C38, 0, "rd_n2_a2");
        xfer(0, 0, 8'h2C, '0, 32'h0, 0, "rd_commit");
        xfer(0, 0, 8'h30, '0, 32'h0, 0, "rd_status");
        xfer(0, 0, 8'h37, '0, 32'hDFE0_0001, 0, "rd_id_unaligned");

        // Shadow write then commit
        xfer(0, 1, 8'h08, 32'hABCD_1234, '0, 0, "wr_n1_b1");
        xfer(0, 0, 8'h08, '0, 32'h1234, 0, "rd_n1_b1_new");
        xfer(0, 0, 8'h30, '0, 32'h1, 0, "status_n1_pend");
        chk("n1_active_before_commit", 128'(coeff_notch_1), 128'(EXP_N1_RST));
        xfer(0, 1, 8'h2C, 32'h1, '0, 0, "commit_n1");
        idle(1);
        chk("n1_active_after_commit", 128'(coeff_notch_1),
            128'({16'h3C38, 16'h6473, 16'h4000, 16'h1234, 16'h4000}));
        chk("n2_active_untouched", 128'(coeff_notch_2), 128'(EXP_N2_RST));
        xfer(0, 0, 8'h30, '0, 32'h0, 0, "status_after_commit");

        // Dual-bank commit, then COMMIT=0 no-op
        xfer(0, 1, 8'h04, 32'h0F0F, '0, 0, "wr_n1_b0");
        xfer(0, 1, 8'h28, 32'h5555, '0, 0, "wr_n2_a2");
        xfer(0, 0, 8'h30, '0, 32'h3, 0, "status_both_pend");
        xfer(0, 1, 8'h2C, 32'h3, '0, 0, "commit_both");
        idle(1);
        chk("n1_active_both", 128'(coeff_notch_1),
            128'({16'h3C38, 16'h6473, 16'h4000, 16'h1234, 16'h0F0F}));
        chk("n2_active_both", 128'(coeff_notch_2),
            128'({16'h5555, 16'hC1EC, 16'h4000, 16'hC000, 16'h4000}));
        xfer(0, 1, 8'h18, 32'h7777, '0, 0, "wr_n2_b0");
        xfer(0, 1, 8'h2C, 32'h0, '0, 0, "commit_zero");
        idle(1);
        xfer(0, 0, 8'h30, '0, 32'h2, 0, "status_n2_still_pend");
        chk("n2_active_noop", 128'(coeff_notch_2),
            128'({16'h5555, 16'hC1EC, 16'h4000, 16'hC000, 16'h4000}));

        // CTRL decimation limit
        xfer(0, 1, 8'h00, 32'h0A01, '0, 1, "wr_ctrl_k5");
        xfer(0, 0, 8'h00, '0, 32'h0AA, 0, "ctrl_kept");
        chk("ctrl_en_kept", 128'(ctrl_en), 128'(5'h00));
        xfer(0, 1, 8'h00, 32'hFFFF_F901, '0, 0, "wr_ctrl_k4");
        idle(1);
        chk("dec_k4", 128'(cic_dec_factor), 128'(3'd4));
        chk("ctrl_en_k4", 128'(ctrl_en), 128'(5'h11));
        chk("bypass_k4", 128'(ctrl_bypass), 128'(4'h0));
        xfer(0, 0, 8'h00, '0, 32'h901, 0, "rd_ctrl_k4");

        // Unmapped and read-only errors
        xfer(0, 0, 8'h3C, '0, 32'h0, 1, "rd_unmapped");
        xfer(0, 1, 8'h34, 32'h1234_5678, '0, 1, "wr_id");
        xfer(0, 1, 8'h30, 32'h0, '0, 1, "wr_status");
        xfer(0, 0, 8'h34, '0, 32'hDFE0_0001, 0, "id_unchanged");
        xfer(0, 0, 8'h30, '0, 32'h2, 0, "status_unchanged");

        // Three wait states
        @(posedge CLK); #1;
        PSEL3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h003;
        @(posedge CLK); #1 PENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("ws3_pready_c%0d", i), 128'(PREADY3), 128'(i == 3));
        end
        @(posedge CLK); #1 PSEL3 = 1'b0; PENABLE = 1'b0;
        xfer(1, 0, 8'h00, '0, 32'h003, 0, "ws3_rd_ctrl");
        chk("ws3_ctrl_en", 128'(ctrl_en3), 128'(5'h01));
        @(posedge CLK); #1;
        PSEL3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h005;
        @(posedge CLK); #1 PENABLE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk($sformatf("ws3_abort_pready_c%0d", i), 128'(PREADY3), 128'(1'b0));
        end
        @(posedge CLK); #1 PSEL3 = 1'b0; PENABLE = 1'b0;
        xfer(1, 0, 8'h00, '0, 32'h003, 0, "ws3_abort_no_write");

        // Reset between setup and access of a CTRL write
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h001;
        #3 RST = 1'b0;
        #1;
        chk("midrst_ctrl_en", 128'(ctrl_en), 128'(5'h00));
        chk("midrst_bypass", 128'(ctrl_bypass), 128'(4'hF));
        chk("midrst_dec", 128'(cic_dec_factor), 128'(3'd0));
        chk("midrst_n1", 128'(coeff_notch_1), 128'(EXP_N1_RST));
        chk("midrst_n2", 128'(coeff_notch_2), 128'(EXP_N2_RST));
        @(posedge CLK); #1 PENABLE = 1'b1;
        #1;
        chk("midrst_pready", 128'(PREADY), 128'(1'b0));
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; RST = 1'b1;
        idle(2);
        xfer(0, 0, 8'h00, '0, 32'h0AA, 0, "postrst_ctrl");
        xfer(0, 0, 8'h30, '0, 32'h0, 0, "postrst_status");
        xfer(0, 0, 8'h08, '0, 32'h678E, 0, "postrst_n1_b1");
        chk("postrst_ctrl_en", 128'(ctrl_en), 128'(5'h00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
